gpio_defaults_serializer: RTL and testbench

Holds the power-on configuration words for a bank of GPIO pads and shifts them serially into the daisy-chained GPIO control blocks. Each channel's reset value is fixed by a parameter. Firmware can overwrite individual words through a simple write port before triggering a reload. The block sits in the housekeeping domain, between the register interface and the GPIO configuration shift chain.

---
 rtl/gpio_defaults_serializer_if.sv | 31 +++
 rtl/gpio_defaults_serializer.sv | 150 +++++++++++++++
 tb/tb_gpio_defaults_serializer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/gpio_defaults_serializer_if.sv
// Register-side and shift-chain signals of the GPIO defaults serializer.
// The slave modport is the serializer; the master modport is firmware / chain model.
interface gpio_defaults_serializer_if #(
  parameter int NUM_GPIO  = 19,
  parameter int CFG_WIDTH = 13
);
  localparam int IDX_W = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1;

  logic                 start;
  logic                 wr_en;
  logic [IDX_W-1:0]     wr_idx;
  logic [CFG_WIDTH-1:0] wr_data;
  logic [IDX_W-1:0]     rd_idx;
  logic [CFG_WIDTH-1:0] rd_data;
  logic                 wr_err;
  logic                 serial_clock;
  logic                 serial_data;
  logic                 serial_load;
  logic                 busy;
  logic                 done;

  modport slave (
    input  start, wr_en, wr_idx, wr_data, rd_idx,
    output rd_data, wr_err, serial_clock, serial_data, serial_load, busy, done
  );

  modport master (
    output start, wr_en, wr_idx, wr_data, rd_idx,
    input  rd_data, wr_err, serial_clock, serial_data, serial_load, busy, done
  );
endinterface

// File: rtl/gpio_defaults_serializer.sv
// Holds per-pad GPIO configuration words and shifts them, last channel first and
// MSB first, into the daisy-chained pad control blocks, then strobes serial_load.
module gpio_defaults_serializer #(
  parameter int                            NUM_GPIO         = 19,
  parameter int                            CFG_WIDTH        = 13,
  parameter logic [NUM_GPIO*CFG_WIDTH-1:0] GPIO_CONFIG_INIT = {19{13'h0402}},
  parameter int                            CLK_DIV          = 2,
  parameter int                            AUTO_LOAD        = 1
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  gpio_defaults_serializer_if.slave  bus
);
  localparam int N     = NUM_GPIO * CFG_WIDTH;
  localparam int IDX_W = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD, DONE} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 auto_q, auto_d;
  logic [CFG_WIDTH-1:0] cfg_q [NUM_GPIO];
  logic                 sclk_q, sclk_d;
  logic                 sdata_q, sdata_d;
  logic                 sload_q, sload_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 wr_err_q, wr_err_d;

  logic [N-1:0]         image;
  logic                 wr_hit;
  logic [CFG_WIDTH-1:0] rd_word;
  logic                 div_last;

  // Bit k of the flattened image is shifted when the bit counter equals k.
  always_comb begin
    for (int i = 0; i < NUM_GPIO; i++) image[i*CFG_WIDTH +: CFG_WIDTH] = cfg_q[i];
  end

  always_comb begin
    wr_hit  = 1'b0;
    rd_word = '0;
    for (int i = 0; i < NUM_GPIO; i++) begin
      if (bus.wr_idx == IDX_W'(i)) wr_hit = 1'b1;
      if (bus.rd_idx == IDX_W'(i)) rd_word = cfg_q[i];
    end
  end

  assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
  assign wr_err_d = bus.wr_en && (busy_q || !wr_hit);

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    auto_d  = auto_q;
    case (state_q)
      IDLE: begin
        if (bus.start || auto_q) begin
          state_d = SHIFT_LO;
          cnt_d   = CNT_W'(N - 1);
          div_d   = '0;
          auto_d  = 1'b0;
        end
      end
      SHIFT_LO: begin
        div_d = div_q + 1'b1;
        if (div_last) begin
          div_d   = '0;
          state_d = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        div_d = div_q + 1'b1;
        if (div_last) begin
          div_d = '0;
          if (cnt_q == '0) begin
            state_d = LOAD;
          end else begin
            cnt_d   = cnt_q - 1'b1;
            state_d = SHIFT_LO;
          end
        end
      end
      LOAD: begin
        div_d = div_q + 1'b1;
        if (div_last) begin
          div_d   = '0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so the chain sees glitch-free strobes.
    sclk_d  = (state_d == SHIFT_HI);
    sload_d = (state_d == LOAD);
    busy_d  = (state_d == SHIFT_LO) || (state_d == SHIFT_HI) || (state_d == LOAD);
    done_d  = (state_d == DONE);
    sdata_d = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? image[cnt_d] : 1'b0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      auto_q   <= (AUTO_LOAD != 0);
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
      sload_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
      // NOTE: the config words are real reset state (power-on pad defaults), so
      // this storage is reset explicitly rather than left as uninitialised memory.
      for (int i = 0; i < NUM_GPIO; i++)
        cfg_q[i] <= GPIO_CONFIG_INIT[i*CFG_WIDTH +: CFG_WIDTH];
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      auto_q   <= auto_d;
      sclk_q   <= sclk_d;
      sdata_q  <= sdata_d;
      sload_q  <= sload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
      if (bus.wr_en && !busy_q) begin
        for (int i = 0; i < NUM_GPIO; i++)
          if (bus.wr_idx == IDX_W'(i)) cfg_q[i] <= bus.wr_data;
      end
    end
  end

  assign bus.rd_data      = rd_word;
  assign bus.wr_err       = wr_err_q;
  assign bus.serial_clock = sclk_q;
  assign bus.serial_data  = sdata_q;
  assign bus.serial_load  = sload_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
endmodule

// File: tb/tb_gpio_defaults_serializer.sv
// Directed bench: three serializer instances cover streaming, writes, ignored
// starts, out-of-range indices, and reset abort with auto-restart.
module tb_gpio_defaults_serializer;
  logic clk;
  logic rst_a;
  logic rst_b;
  int   total  = 0;
  int   passed = 0;
  int   fails  = 0;

  localparam logic [25:0] INIT2 = {13'h1803, 13'h0402};
  localparam logic [38:0] INIT3 = {13'h0111, 13'h1803, 13'h0402};

  gpio_defaults_serializer_if #(.NUM_GPIO(2), .CFG_WIDTH(13)) ifa ();
  gpio_defaults_serializer_if #(.NUM_GPIO(2), .CFG_WIDTH(13)) ifb ();
  gpio_defaults_serializer_if #(.NUM_GPIO(3), .CFG_WIDTH(13)) ifc ();

  gpio_defaults_serializer #(.NUM_GPIO(2), .CFG_WIDTH(13), .GPIO_CONFIG_INIT(INIT2),
    .CLK_DIV(1), .AUTO_LOAD(0)) dut_a (.wb_clk_i(clk), .wb_rst_i(rst_a), .bus(ifa));
  gpio_defaults_serializer #(.NUM_GPIO(2), .CFG_WIDTH(13), .GPIO_CONFIG_INIT(INIT2),
    .CLK_DIV(3), .AUTO_LOAD(1)) dut_b (.wb_clk_i(clk), .wb_rst_i(rst_b), .bus(ifb));
  gpio_defaults_serializer #(.NUM_GPIO(3), .CFG_WIDTH(13), .GPIO_CONFIG_INIT(INIT3),
    .CLK_DIV(1), .AUTO_LOAD(0)) dut_c (.wb_clk_i(clk), .wb_rst_i(rst_a), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Watches dut_a for a fixed window starting at the first busy cycle, optionally
  // injecting a write (idx0 <= 0AAA) and start pulses at given cycle indices.
  task automatic mon_a(input int wr_c, input int st1, input int st2,
                       output logic [25:0] bits, output int rises, output int busy_n,
                       output int load_n, output int load_c, output int done_n,
                       output int done_c, output int werr_n);
    logic prev = 1'b0;
    bits = '0; rises = 0; busy_n = 0; load_n = 0; load_c = -1;
    done_n = 0; done_c = -1; werr_n = 0;
    for (int c = 0; c < 120; c++) begin
      if (ifa.serial_clock && !prev) begin
        bits = {bits[24:0], ifa.serial_data};
        rises++;
      end
      prev = ifa.serial_clock;
      if (ifa.busy) busy_n++;
      if (ifa.serial_load) begin load_n++; load_c = c; end
      if (ifa.done) begin done_n++; done_c = c; end
      if (ifa.wr_err) werr_n++;
      ifa.wr_en   = (c == wr_c);
      ifa.wr_idx  = 1'b0;
      ifa.wr_data = 13'h0AAA;
      ifa.start   = (c == st1) || (c == st2);
      tick();
    end
    ifa.wr_en = 1'b0;
    ifa.start = 1'b0;
  endtask

  // Watches dut_b from its first busy cycle until done (bounded).
  task automatic mon_b(output logic [25:0] bits, output int busy_n, output int done_c);
    logic prev = 1'b0;
    bits = '0; busy_n = 0; done_c = -1;
    for (int c = 0; c < 400; c++) begin
      if (ifb.serial_clock && !prev) bits = {bits[24:0], ifb.serial_data};
      prev = ifb.serial_clock;
      if (ifb.busy) busy_n++;
      if (ifb.done) begin done_c = c; break; end
      tick();
    end
  endtask

  task automatic start_a();
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
  endtask

  initial begin
    logic [25:0] bits;
    int rises, busy_n, load_n, load_c, done_n, done_c, werr_n;
    logic prev;

    rst_a = 1'b1; rst_b = 1'b1;
    ifa.start = 0; ifa.wr_en = 0; ifa.wr_idx = 0; ifa.wr_data = 0; ifa.rd_idx = 0;
    ifb.start = 0; ifb.wr_en = 0; ifb.wr_idx = 0; ifb.wr_data = 0; ifb.rd_idx = 0;
    ifc.start = 0; ifc.wr_en = 0; ifc.wr_idx = 0; ifc.wr_data = 0; ifc.rd_idx = 0;
    tick(); tick();

    // Reset state
    check("rst_outs", {ifa.serial_clock, ifa.serial_data, ifa.serial_load,
                       ifa.busy, ifa.done, ifa.wr_err}, 0);
    ifa.rd_idx = 1'b0; #1;
    check("rst_rd0", ifa.rd_data, 13'h0402);
    ifa.rd_idx = 1'b1; #1;
    check("rst_rd1", ifa.rd_data, 13'h1803);
    ifa.rd_idx = 1'b0;
    rst_a = 1'b0;
    tick(); tick();
    check("idle_outs", {ifa.serial_clock, ifa.serial_data, ifa.serial_load,
                        ifa.busy, ifa.done, ifa.wr_err}, 0);

    // Out-of-range index on a 3-channel instance
    ifc.wr_en = 1'b1; ifc.wr_idx = 2'd3; ifc.wr_data = 13'h1234;
    tick();
    ifc.wr_en = 1'b0;
    check("oor_werr", ifc.wr_err, 1);
    tick();
    check("oor_werr_1cyc", ifc.wr_err, 0);
    ifc.rd_idx = 2'd3; #1;
    check("oor_rd", ifc.rd_data, 0);
    ifc.rd_idx = 2'd2; #1;
    check("c_rd2", ifc.rd_data, 13'h0111);

    // Plain stream, CLK_DIV=1
    start_a();
    check("start_busy", ifa.busy, 1);
    mon_a(-1, -1, -1, bits, rises, busy_n, load_n, load_c, done_n, done_c, werr_n);
    check("s1_rises", rises, 26);
    check("s1_bits", bits, {13'h1803, 13'h0402});
    check("s1_busy", busy_n, 53);
    check("s1_load_n", load_n, 1);
    check("s1_load_c", load_c, 52);
    check("s1_done_n", done_n, 1);
    check("s1_done_c", done_c, 53);
    check("s1_after", {ifa.serial_clock, ifa.serial_data, ifa.serial_load,
                       ifa.busy, ifa.done}, 0);

    // Write then load
    ifa.wr_en = 1'b1; ifa.wr_idx = 1'b0; ifa.wr_data = 13'h1FFF;
    tick();
    ifa.wr_en = 1'b0;
    check("wr_ok_err", ifa.wr_err, 0);
    check("wr_rd0", ifa.rd_data, 13'h1FFF);
    ifa.rd_idx = 1'b1; #1;
    check("wr_rd1", ifa.rd_data, 13'h1803);
    ifa.rd_idx = 1'b0;
    start_a();
    mon_a(-1, -1, -1, bits, rises, busy_n, load_n, load_c, done_n, done_c, werr_n);
    check("s2_low", bits[12:0], 13'h1FFF);
    check("s2_high", bits[25:13], 13'h1803);

    // Write during busy is dropped
    start_a();
    mon_a(10, -1, -1, bits, rises, busy_n, load_n, load_c, done_n, done_c, werr_n);
    check("bw_werr", werr_n, 1);
    check("bw_bits", bits, {13'h1803, 13'h1FFF});
    check("bw_rd0", ifa.rd_data, 13'h1FFF);

    // Start in SHIFT_HI and in LOAD ignored
    start_a();
    mon_a(-1, 5, 52, bits, rises, busy_n, load_n, load_c, done_n, done_c, werr_n);
    check("ig_done_n", done_n, 1);
    check("ig_busy", busy_n, 53);
    check("ig_bits", bits, {13'h1803, 13'h1FFF});

    // Start in DONE ignored, start right after DONE accepted
    start_a();
    mon_a(-1, 53, 54, bits, rises, busy_n, load_n, load_c, done_n, done_c, werr_n);
    check("b2b_done_n", done_n, 2);
    check("b2b_done_c", done_c, 108);
    check("b2b_busy", busy_n, 106);

    // Auto-load after reset, CLK_DIV=3
    rst_b = 1'b0;
    check("al_idle", ifb.busy, 0);
    tick();
    check("al_busy", ifb.busy, 1);
    mon_b(bits, busy_n, done_c);
    check("al_busy_n", busy_n, 159);
    check("al_done_c", done_c, 159);
    check("al_bits", bits, {13'h1803, 13'h0402});
    ifb.wr_en = 1'b1; ifb.wr_idx = 1'b0; ifb.wr_data = 13'h1FFF;
    tick();
    ifb.wr_en = 1'b0;
    check("b_wr_rd0", ifb.rd_data, 13'h1FFF);

    // Abort at bit 10, then auto-restart from INIT
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    rises = 0; prev = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (ifb.serial_clock && !prev) rises++;
      prev = ifb.serial_clock;
      if (rises == 10) break;
      tick();
    end
    check("ab_rises", rises, 10);
    rst_b = 1'b1;
    tick();
    check("ab_outs", {ifb.serial_clock, ifb.serial_data, ifb.serial_load,
                      ifb.busy, ifb.done, ifb.wr_err}, 0);
    check("ab_rd0", ifb.rd_data, 13'h0402);
    rst_b = 1'b0;
    check("ab_idle", ifb.busy, 0);
    tick();
    check("ab_busy", ifb.busy, 1);
    mon_b(bits, busy_n, done_c);
    check("ab_busy_n", busy_n, 159);
    check("ab_done_c", done_c, 159);
    check("ab_bits", bits, {13'h1803, 13'h0402});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
